// File: rtl/defog_frame_ctrl.sv
// rtl/defog_frame_ctrl.sv - frame-boundary sequencer for the dehaze pipeline (optional DEFOG_SCENE_CUT_EN)
module defog_frame_ctrl #(
    parameter int          H_ACTIVE     = 1280,
    parameter int          V_ACTIVE     = 720,
    parameter int          ALPHA_SHIFT  = 3,
    parameter logic [7:0]  THRE_INIT    = 8'd200,
    parameter logic [7:0]  SCENE_CUT_TH = 8'd64
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    input  logic [7:0]  cfg_thre,
    input  logic        cfg_bypass,
    input  logic [7:0]  i_dark_max,
    output logic [7:0]  o_thre,
    output logic        o_bypass,
    output logic [7:0]  o_airlight,
    output logic        o_airlight_valid,
    output logic        o_frame_start,
    output logic        o_frame_done,
    output logic [15:0] o_frame_cnt,
    output logic        o_geom_err
);

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE, S_UPDATE} state_e;

    state_e       state_q;
    logic         vs_q, de_q;
    logic [15:0]  pix_cnt_q;
    logic [11:0]  line_cnt_q;
    logic         err_q;
    logic [7:0]   thre_q, airlight_q;
    logic         bypass_q, airlight_valid_q, frame_start_q, frame_done_q, geom_err_q;
    logic [15:0]  frame_cnt_q;

    logic         vs_lead, de_rise, de_fall;
    logic [15:0]  pix_inc;
    logic [11:0]  line_inc;
    logic signed [8:0] diff_s, step_s, sum_s;
    logic [8:0]   diff_abs;
    logic         scene_cut;
    logic [7:0]   airlight_d;

    // Sync is only observed for monitoring; the top sum bit is always zero since the step never overshoots
    logic unused_hsync_sum;
    assign unused_hsync_sum = ^{i_hsync, sum_s[8]};

    // Edge detection and saturating counter increments
    always_comb begin
        vs_lead  = i_vsync & ~vs_q;
        de_rise  = i_de & ~de_q;
        de_fall  = ~i_de & de_q;
        pix_inc  = (&pix_cnt_q)  ? pix_cnt_q  : pix_cnt_q + 16'd1;
        line_inc = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 12'd1;
    end

    // IIR step with a 9-bit signed difference and flooring shift; result stays between a and d
    always_comb begin
        diff_s    = $signed({1'b0, i_dark_max}) - $signed({1'b0, airlight_q});
        step_s    = diff_s >>> ALPHA_SHIFT;
        sum_s     = $signed({1'b0, airlight_q}) + step_s;
        diff_abs  = diff_s[8] ? $unsigned(-diff_s) : $unsigned(diff_s);
        scene_cut = diff_abs > {1'b0, SCENE_CUT_TH};
`ifdef DEFOG_SCENE_CUT_EN
        airlight_d = scene_cut ? i_dark_max : sum_s[7:0];
`else
        airlight_d = sum_s[7:0];
`endif
    end

`ifndef DEFOG_SCENE_CUT_EN
    logic unused_scene_cut;
    assign unused_scene_cut = scene_cut;
`endif

    // Frame FSM: geometry counting during the frame, parameter commit in the one-cycle update state
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_SYNC;
            vs_q             <= 1'b0;
            de_q             <= 1'b0;
            pix_cnt_q        <= '0;
            line_cnt_q       <= '0;
            err_q            <= 1'b0;
            thre_q           <= THRE_INIT;
            bypass_q         <= 1'b1;
            airlight_q       <= '0;
            airlight_valid_q <= 1'b0;
            frame_start_q    <= 1'b0;
            frame_done_q     <= 1'b0;
            frame_cnt_q      <= '0;
            geom_err_q       <= 1'b0;
        end else begin
            vs_q          <= i_vsync;
            de_q          <= i_de;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                S_SYNC: begin
                    if (vs_lead) begin
                        state_q    <= S_VBLANK;
                        pix_cnt_q  <= '0;
                        line_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                S_VBLANK: begin
                    if (vs_lead) begin
                        state_q <= S_UPDATE;
                    end else if (de_rise) begin
                        state_q       <= S_ACTIVE;
                        frame_start_q <= 1'b1;
                        pix_cnt_q     <= 16'd1;
                    end
                end
                S_ACTIVE: begin
                    if (de_fall) begin
                        if (pix_cnt_q != 16'(H_ACTIVE)) err_q <= 1'b1;
                        line_cnt_q <= line_inc;
                        pix_cnt_q  <= '0;
                    end else if (vs_lead && i_de) begin
                        err_q      <= 1'b1;
                        line_cnt_q <= line_inc;
                        pix_cnt_q  <= '0;
                    end else if (i_de) begin
                        pix_cnt_q <= pix_inc;
                    end
                    if (vs_lead) state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    state_q      <= S_VBLANK;
                    thre_q       <= cfg_thre;
                    bypass_q     <= cfg_bypass;
                    geom_err_q   <= err_q | (line_cnt_q != 12'(V_ACTIVE));
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                    err_q        <= 1'b0;
                    line_cnt_q   <= '0;
                    pix_cnt_q    <= '0;
                    frame_done_q <= 1'b1;
                    if (!airlight_valid_q) begin
                        airlight_q       <= i_dark_max;
                        airlight_valid_q <= 1'b1;
                    end else begin
                        airlight_q <= airlight_d;
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    assign o_thre           = thre_q;
    assign o_bypass         = bypass_q;
    assign o_airlight       = airlight_q;
    assign o_airlight_valid = airlight_valid_q;
    assign o_frame_start    = frame_start_q;
    assign o_frame_done     = frame_done_q;
    assign o_frame_cnt      = frame_cnt_q;
    assign o_geom_err       = geom_err_q;

endmodule

// File: tb/tb_defog_frame_ctrl.sv
// tb/tb_defog_frame_ctrl.sv - scoreboard bench for defog_frame_ctrl
module tb_defog_frame_ctrl;

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic        i_hsync, i_vsync, i_de;
    logic [7:0]  cfg_thre;
    logic        cfg_bypass;
    logic [7:0]  i_dark_max;
    logic [7:0]  o_thre, o_airlight;
    logic        o_bypass, o_airlight_valid, o_frame_start, o_frame_done, o_geom_err;
    logic [15:0] o_frame_cnt;

    defog_frame_ctrl #(
        .H_ACTIVE(16), .V_ACTIVE(4), .ALPHA_SHIFT(3),
        .THRE_INIT(8'd200), .SCENE_CUT_TH(8'd64)
    ) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .i_de(i_de), .cfg_thre(cfg_thre), .cfg_bypass(cfg_bypass), .i_dark_max(i_dark_max),
        .o_thre(o_thre), .o_bypass(o_bypass), .o_airlight(o_airlight),
        .o_airlight_valid(o_airlight_valid), .o_frame_start(o_frame_start),
        .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt), .o_geom_err(o_geom_err)
    );

    always #5 pixelclk = ~pixelclk;

    typedef struct {
        logic [7:0]  air;
        logic        valid;
        logic [15:0] cnt;
        logic [7:0]  thre;
        logic        bypass;
        logic        geom;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int          m_lines;
    bit          m_err, m_synced, m_started, m_valid, m_bypass;
    logic [7:0]  m_a, m_thre;
    logic [15:0] m_cnt;
    int          m_starts = 0;
    int          seen_starts = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_air(input int a, input int d);
        int diff;
        int step;
        diff = d - a;
`ifdef DEFOG_SCENE_CUT_EN
        if (diff > 64 || diff < -64) return 8'(d);
`endif
        if (diff >= 0) step = diff / 8;
        else           step = -((-diff + 7) / 8);
        return 8'(a + step);
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending frame commit
    always @(negedge pixelclk) begin
        exp_t e;
        if (o_frame_start) seen_starts++;
        if (o_frame_done) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                check("sb_airlight", 16'(o_airlight), 16'(e.air));
                check("sb_valid", 16'(o_airlight_valid), 16'(e.valid));
                check("sb_frame_cnt", o_frame_cnt, e.cnt);
                check("sb_thre", 16'(o_thre), 16'(e.thre));
                check("sb_bypass", 16'(o_bypass), 16'(e.bypass));
                check("sb_geom_err", 16'(o_geom_err), 16'(e.geom));
            end
        end
    end

    task automatic model_reset();
        m_synced = 0; m_valid = 0; m_a = 8'd0; m_cnt = 16'd0;
        m_thre = 8'd200; m_bypass = 1; m_err = 0; m_lines = 0; m_started = 0;
    endtask

    task automatic lines(input int n, input int px);
        for (int l = 0; l < n; l++) begin
            if (m_synced && !m_started) begin
                m_starts++;
                m_started = 1;
            end
            for (int k = 0; k < px; k++) begin
                @(negedge pixelclk); i_de = 1'b1;
            end
            @(negedge pixelclk); i_de = 1'b0; i_hsync = 1'b1;
            @(negedge pixelclk); i_hsync = 1'b0;
            @(negedge pixelclk);
        end
        m_lines += n;
        if (px != 16) m_err = 1;
    endtask

    task automatic vs_frame(input logic [7:0] d);
        exp_t e;
        bit   commit;
        commit = m_synced;
        @(negedge pixelclk);
        i_dark_max = d;
        i_vsync    = 1'b1;
        if (commit) begin
            e.air    = m_valid ? model_air(m_a, d) : d;
            e.valid  = 1'b1;
            e.cnt    = m_cnt + 16'd1;
            e.thre   = cfg_thre;
            e.bypass = cfg_bypass;
            e.geom   = m_err || (m_lines != 4);
            sb.push_back(e);
        end
        @(negedge pixelclk);
        check("done_edge_n", 16'(o_frame_done), 16'd0);
        check("thre_hold_n", 16'(o_thre), 16'(m_thre));
        check("bypass_hold_n", 16'(o_bypass), 16'(m_bypass));
        @(negedge pixelclk);
        check("done_edge_n1", 16'(o_frame_done), 16'(commit));
        if (commit) begin
            m_a = e.air; m_valid = 1; m_cnt = e.cnt; m_thre = e.thre; m_bypass = e.bypass;
        end else begin
            check("nocommit_cnt", o_frame_cnt, m_cnt);
            m_synced = 1;
        end
        @(negedge pixelclk); i_vsync = 1'b0;
        repeat (2) @(negedge pixelclk);
        m_err = 0; m_lines = 0; m_started = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_thre"}, 16'(o_thre), 16'd200);
        check({tag, "_bypass"}, 16'(o_bypass), 16'd1);
        check({tag, "_airlight"}, 16'(o_airlight), 16'd0);
        check({tag, "_valid"}, 16'(o_airlight_valid), 16'd0);
        check({tag, "_start"}, 16'(o_frame_start), 16'd0);
        check({tag, "_done"}, 16'(o_frame_done), 16'd0);
        check({tag, "_cnt"}, o_frame_cnt, 16'd0);
        check({tag, "_geom"}, 16'(o_geom_err), 16'd0);
    endtask

    task automatic reset_midframe();
        lines(1, 16);
        for (int k = 0; k < 5; k++) begin
            @(negedge pixelclk); i_de = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        i_de = 1'b0;
        model_reset();
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
        repeat (2) @(negedge pixelclk);
    endtask

    initial begin
        reset_n = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
        cfg_thre = 8'd200; cfg_bypass = 1'b0; i_dark_max = 8'd0;
        model_reset();
        repeat (3) @(negedge pixelclk);
        check_reset_values("rst");
        reset_n = 1'b1;
        @(negedge pixelclk);

        // Three frames of constant airlight 120; first VS only synchronises
        vs_frame(8'd120);
        check("first_vs_valid", 16'(o_airlight_valid), 16'd0);
        check("first_vs_bypass", 16'(o_bypass), 16'd1);
        lines(4, 16); vs_frame(8'd120);
        check("f1_airlight", 16'(o_airlight), 16'd120);
        check("f1_valid", 16'(o_airlight_valid), 16'd1);
        check("f1_cnt", o_frame_cnt, 16'd1);
        check("f1_bypass", 16'(o_bypass), 16'd0);
        lines(4, 16); vs_frame(8'd120);
        lines(4, 16); vs_frame(8'd120);
        check("f3_cnt", o_frame_cnt, 16'd3);

        // Mid-frame reset: first VS ignored, next loads directly, count restarts
        reset_midframe();
        vs_frame(8'd50);
        check("post_rst_ignored_valid", 16'(o_airlight_valid), 16'd0);
        lines(4, 16); vs_frame(8'd200);
        check("post_rst_reload", 16'(o_airlight), 16'd200);
        check("post_rst_cnt", o_frame_cnt, 16'd1);

        // IIR from a=200, d=170
        lines(4, 16); vs_frame(8'd170);
        check("iir_200_170", 16'(o_airlight), 16'd196);

        // IIR from a=100, d=200, then d equal to a
        reset_midframe();
        vs_frame(8'd0);
        lines(4, 16); vs_frame(8'd100);
        lines(4, 16); vs_frame(8'd200);
        check("iir_100_200", 16'(o_airlight), 16'd112);
        lines(4, 16); vs_frame(8'd112);
        check("iir_equal", 16'(o_airlight), 16'd112);

        // Large step: scene cut behaviour depends on build
        reset_midframe();
        vs_frame(8'd0);
        lines(4, 16); vs_frame(8'd200);
        lines(4, 16); vs_frame(8'd100);
`ifdef DEFOG_SCENE_CUT_EN
        check("scene_cut_200_100", 16'(o_airlight), 16'd100);
`else
        check("scene_cut_200_100", 16'(o_airlight), 16'd187);
`endif

        // Config changed mid-frame commits only at the boundary
        lines(2, 16);
        cfg_thre = 8'd150; cfg_bypass = 1'b1;
        lines(1, 16);
        check("thre_midframe", 16'(o_thre), 16'd200);
        check("bypass_midframe", 16'(o_bypass), 16'd0);
        lines(1, 16); vs_frame(8'd100);
        check("thre_committed", 16'(o_thre), 16'd150);
        check("bypass_committed", 16'(o_bypass), 16'd1);

        // Geometry: short line, short frame, then a correct frame
        lines(3, 16); lines(1, 15); vs_frame(8'd100);
        check("geom_short_line", 16'(o_geom_err), 16'd1);
        lines(3, 16); vs_frame(8'd100);
        check("geom_short_frame", 16'(o_geom_err), 16'd1);
        lines(4, 16); vs_frame(8'd100);
        check("geom_ok", 16'(o_geom_err), 16'd0);

        repeat (4) @(negedge pixelclk);
        check("sb_drained", 16'(sb.size()), 16'd0);
        check("frame_start_pulses", 16'(seen_starts), 16'(m_starts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/defog_frame_ctrl.md
Name: defog_frame_ctrl

Overview:
- Frame-level sequencer for the three-stage dehaze pipeline (dark channel -> transmittance/atmospheric light -> restoration).
- Tracks input video timing and applies new configuration (threshold, bypass) only at frame boundaries.
- Temporally smooths the per-frame atmospheric light estimate with an IIR filter, so the restoration stage never sees mid-frame or flickering parameter changes.
- Also checks frame geometry and reports frame start/done events.

Parameters:
- H_ACTIVE, 1280, expected active pixels per line (DE-high run length).
- V_ACTIVE, 720, expected active lines per frame (DE runs between VSYNC leading edges).
- ALPHA_SHIFT, 3, IIR weight: a += (d - a) >>> ALPHA_SHIFT.
- THRE_INIT, 8'd200, o_thre value after reset.
- SCENE_CUT_TH, 8'd64, scene-cut distance (used only with DEFOG_SCENE_CUT_EN).

Ports:
- pixelclk  in  1  pixel clock; single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- i_hsync  in  1  input horizontal sync, active-high.
- i_vsync  in  1  input vertical sync, active-high.
- i_de  in  1  input data enable.
- cfg_thre  in  8  requested atmospheric-light threshold; shadow value, sampled only at frame boundary.
- cfg_bypass  in  1  requested pass-through mode; shadow value, sampled only at frame boundary.
- i_dark_max  in  8  per-frame atmospheric light measurement from stage 2; valid at VSYNC leading edge.
- o_thre  out  8  frame-stable threshold driven to stage 2.
- o_bypass  out  1  frame-stable bypass flag driven to output mux.
- o_airlight  out  8  smoothed atmospheric light driven to stage 3.
- o_airlight_valid  out  1  high once at least one full frame has been measured.
- o_frame_start  out  1  one-cycle pulse at first DE of a frame.
- o_frame_done  out  1  one-cycle pulse when boundary update commits.
- o_frame_cnt  out  16  completed-frame counter; wraps 16'hFFFF -> 0.
- o_geom_err  out  1  previous frame geometry mismatch; level, refreshed each boundary.

Behaviour:
- Reset values (asynchronous, applied whenever reset_n=0):
  - o_thre = THRE_INIT; o_bypass = 1; o_airlight = 0.
  - o_airlight_valid = 0; o_frame_start = 0; o_frame_done = 0.
  - o_frame_cnt = 0; o_geom_err = 0.
  - State returns to S_SYNC; all counters and edge registers are cleared.
  - Reset mid-frame discards that partial frame.
- Edge detect: vs_d, de_d are registered copies of the inputs.
  - VS leading edge = i_vsync & ~vs_d.
  - DE rise = i_de & ~de_d; DE fall = ~i_de & de_d.
- FSM states:
  - S_SYNC (after reset): ignore everything until a VS leading edge -> S_VBLANK. No update on this edge, because the frame before it was partial.
  - S_VBLANK: DE rise -> S_ACTIVE, pulse o_frame_start for that cycle. VS leading edge (empty frame) -> S_UPDATE with line count 0.
  - S_ACTIVE: count pixels while i_de=1. On DE fall, compare the pixel count to H_ACTIVE; a mismatch sets the internal err flag. Then increment the line count and clear the pixel count. VS leading edge -> S_UPDATE. If i_de=1 on that edge, close the partial line, which counts as a mismatch.
  - S_UPDATE (exactly 1 cycle), then -> S_VBLANK. Actions:
    - sample i_dark_max as d;
    - commit o_thre <= cfg_thre and o_bypass <= cfg_bypass;
    - o_geom_err <= err | (line_cnt != V_ACTIVE);
    - o_frame_cnt++; clear err and line_cnt; pulse o_frame_done.
    - Airlight: if o_airlight_valid=0, o_airlight <= d and o_airlight_valid <= 1. Otherwise o_airlight <= a + ((d - a) >>> ALPHA_SHIFT), using 9-bit signed difference and flooring arithmetic shift. The result always lies in [min(a,d), max(a,d)], so no saturation is needed.
- Timing: with i_vsync first sampled high at edge N, S_UPDATE is entered at N. All committed outputs change at N+1, and o_frame_done is high for the cycle following N+1.
- Config stability: cfg_* changes during a frame have no effect until the next S_UPDATE. The last value present at the update cycle wins.
- Simultaneous VS leading edge and DE rise in S_VBLANK: VS wins; the DE is ignored until the next frame.
- Pixel and line counters saturate at all-ones (16-bit pixel, 12-bit line) and never wrap.
- i_hsync is used only for monitoring; the geometry check is DE-based.

Optional Feature:
- Macro DEFOG_SCENE_CUT_EN.
- Defined: in S_UPDATE with o_airlight_valid=1, if |d - a| > SCENE_CUT_TH, then o_airlight <= d directly (hard reload on scene change); otherwise the normal IIR step applies.
- Not defined: the IIR step is always used, and SCENE_CUT_TH is unused.

Test Plan:
- Reset, then 3 frames at H_ACTIVE=16, V_ACTIVE=4, i_dark_max=120 (use these geometry values in all scenarios unless stated). Expect:
  - no commit on the first VS;
  - second VS: o_airlight=120, valid=1, o_frame_cnt=1, o_bypass=cfg_bypass;
  - o_frame_start is one pulse per frame and o_frame_done is one pulse per frame.
- IIR, ALPHA_SHIFT=3, a=200:
  - d=170 -> 196 (floor of -3.75);
  - then a=100, d=200 -> 112;
  - d equal to a -> unchanged.
- Scene cut, a=200, d=100:
  - without the macro -> 187;
  - with DEFOG_SCENE_CUT_EN -> 100;
  - d=170 -> 196 in both builds.
- Config timing: toggle cfg_thre 200->150 mid-frame. Expect o_thre to hold 200 until the edge N+1 after the next VS, then 150. Changing cfg_bypass mid-frame likewise commits only at the boundary.
- Geometry: one line of 15 pixels -> o_geom_err=1 after that frame. A 3-line frame -> o_geom_err=1. A following correct frame -> o_geom_err=0.
- Assert reset_n mid-frame with a=180. Expect all outputs at reset values immediately (asynchronously) and the first post-reset VS ignored. The next VS loads o_airlight=d directly, and o_frame_cnt restarts at 1.
